// File: rtl/vdf_sq_pkg.sv
// Shared types for the VDF squaring sequencer: controller states, the
// default operand geometry and the integer-to-redundant-polynomial mapping.
package vdf_sq_pkg;

  localparam int VDF_WORD_BITS       = 16;
  localparam int VDF_NUM_WORDS       = 64;
  localparam int VDF_REDUN_WORD_BITS = 1;
  localparam int VDF_I_WORD          = VDF_NUM_WORDS + 1;
  localparam int VDF_COEF_BITS       = VDF_WORD_BITS + VDF_REDUN_WORD_BITS;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_FIN_ISSUE = 3'd3,
    ST_FIN_WAIT  = 3'd4,
    ST_DONE      = 3'd5
  } sq_ctrl_state_t;

  typedef logic [VDF_I_WORD-1:0][VDF_COEF_BITS-1:0] poly_t;

  // Word k becomes coefficient k with clear redundant bits; the extra top coefficient is zero.
  function automatic poly_t int_to_poly(input logic [VDF_NUM_WORDS*VDF_WORD_BITS-1:0] x);
    poly_t p;
    p = '0;
    for (int k = 0; k < VDF_NUM_WORDS; k++) begin
      p[k] = {{VDF_REDUN_WORD_BITS{1'b0}}, x[k*VDF_WORD_BITS +: VDF_WORD_BITS]};
    end
    return p;
  endfunction

endpackage

// File: rtl/vdf_sq_watchdog.sv
// Datapath response watchdog: cleared on each issue, counts while a result
// is awaited and flags expiry so the result lands TIMEOUT_CYC after the issue strobe.
module vdf_sq_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  // Counting starts the cycle after issue and the controller registers the
  // error one cycle after expiry, hence the two-cycle offset.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter, saturating at the expiry point
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/vdf_sq_ctrl.sv
// Sequencer for the polynomial modular squaring datapath: runs T feedback
// squarings plus one reduce-only pass and gates LUT writes to idle periods.
module vdf_sq_ctrl
  import vdf_sq_pkg::*;
#(
  parameter int WORD_BITS       = 16,
  parameter int NUM_WORDS       = 64,
  parameter int REDUN_WORD_BITS = 1,
  parameter int I_WORD          = NUM_WORDS + 1,
  parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  parameter int ITER_BITS       = 40,
  parameter int TIMEOUT_CYC     = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  output logic                           o_start_rdy,
  input  logic [NUM_WORDS*WORD_BITS-1:0] i_x,
  input  logic [ITER_BITS-1:0]           i_iter,
  input  logic                           i_abort,
  output logic                           o_val,
  input  logic                           i_rdy,
  output logic [I_WORD*COEF_BITS-1:0]    o_dat,
  output logic                           o_err,
  output logic [ITER_BITS-1:0]           o_iter_cnt,
  output logic                           o_sq_val,
  output logic                           o_sq_reduce_only,
  output logic [I_WORD*COEF_BITS-1:0]    o_sq_dat,
  input  logic                           i_sq_val,
  input  logic [I_WORD*COEF_BITS-1:0]    i_sq_dat,
  input  logic                           i_ram_we,
  input  logic [NUM_WORDS*WORD_BITS-1:0] i_ram_d,
  output logic                           o_ram_we,
  output logic [NUM_WORDS*WORD_BITS-1:0] o_ram_d
);

  localparam int DAT_W = I_WORD * COEF_BITS;
  localparam int X_W   = NUM_WORDS * WORD_BITS;

  sq_ctrl_state_t r_state;
  sq_ctrl_state_t w_next;

  logic                 r_start_rdy;
  logic                 r_val;
  logic                 r_err;
  logic [DAT_W-1:0]     r_dat;
  logic [DAT_W-1:0]     r_operand;
  logic [ITER_BITS-1:0] r_iter_cnt;
  logic [ITER_BITS-1:0] r_t;
  logic                 r_sq_val;
  logic                 r_sq_reduce_only;
  logic                 r_ram_we;
  logic [X_W-1:0]       r_ram_d;

  logic                 w_accept;
  logic                 w_capture;
  logic                 w_fin;
  logic                 w_tmo;
  logic                 w_wd_clear;
  logic                 w_wd_en;
  logic                 w_expired;
  logic                 w_last;
  logic                 w_ram_we;
  logic [ITER_BITS-1:0] w_iter_inc;
  logic [DAT_W-1:0]     w_x_poly;

  vdf_sq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_expired (w_expired)
  );

  // Host integer to redundant operand: word k into coefficient k, redundant bits zero
  always_comb begin
    w_x_poly = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_x_poly[k*COEF_BITS +: WORD_BITS] = i_x[k*WORD_BITS +: WORD_BITS];
    end
  end

  assign w_iter_inc = (r_iter_cnt == {ITER_BITS{1'b1}}) ? r_iter_cnt
                    : r_iter_cnt + {{(ITER_BITS-1){1'b0}}, 1'b1};
  assign w_last     = (w_iter_inc == r_t);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort outranks datapath results and timeout
  always_comb begin
    w_next = r_state;
    if ((r_state != ST_IDLE) && i_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && r_start_rdy) begin
            w_next = (i_iter != {ITER_BITS{1'b0}}) ? ST_ISSUE : ST_FIN_ISSUE;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_ISSUE:     w_next = ST_WAIT;
        ST_WAIT: begin
          if (i_sq_val) begin
            w_next = w_last ? ST_FIN_ISSUE : ST_ISSUE;
          end else if (w_expired) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_WAIT;
          end
        end
        ST_FIN_ISSUE: w_next = ST_FIN_WAIT;
        ST_FIN_WAIT: begin
          if (i_sq_val || w_expired) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_FIN_WAIT;
          end
        end
        ST_DONE: begin
          if (i_rdy) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_DONE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Per-state event decode feeding the registered outputs
  always_comb begin
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_fin      = 1'b0;
    w_tmo      = 1'b0;
    w_wd_clear = 1'b0;
    w_wd_en    = 1'b0;
    w_ram_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = i_start && r_start_rdy;
        w_ram_we = i_ram_we;
      end
      ST_ISSUE, ST_FIN_ISSUE: begin
        w_wd_clear = 1'b1;
      end
      ST_WAIT: begin
        w_wd_en   = 1'b1;
        w_capture = i_sq_val && !i_abort;
        w_tmo     = !i_sq_val && w_expired && !i_abort;
      end
      ST_FIN_WAIT: begin
        w_wd_en = 1'b1;
        w_fin   = i_sq_val && !i_abort;
        w_tmo   = !i_sq_val && w_expired && !i_abort;
      end
      ST_DONE: begin
        w_accept = 1'b0;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // Operand, iteration bookkeeping and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_rdy      <= 1'b1;
      r_val            <= 1'b0;
      r_err            <= 1'b0;
      r_dat            <= '0;
      r_operand        <= '0;
      r_iter_cnt       <= '0;
      r_t              <= '0;
      r_sq_val         <= 1'b0;
      r_sq_reduce_only <= 1'b0;
    end else begin
      r_start_rdy      <= (w_next == ST_IDLE);
      r_val            <= (w_next == ST_DONE);
      r_sq_val         <= (w_next == ST_ISSUE) || (w_next == ST_FIN_ISSUE);
      r_sq_reduce_only <= (w_next == ST_FIN_ISSUE);
      if (w_accept) begin
        r_t        <= i_iter;
        r_operand  <= w_x_poly;
        r_iter_cnt <= '0;
        r_err      <= 1'b0;
      end else if (w_capture) begin
        r_operand  <= i_sq_dat;
        r_iter_cnt <= w_iter_inc;
      end else begin
        r_operand  <= r_operand;
        r_iter_cnt <= r_iter_cnt;
      end
      if (w_fin) begin
        r_dat <= i_sq_dat;
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_dat <= r_operand;
        r_err <= 1'b1;
      end else begin
        r_dat <= r_dat;
      end
    end
  end

  // LUT write forwarding, only while no computation is in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_we <= 1'b0;
      r_ram_d  <= '0;
    end else begin
      r_ram_we <= w_ram_we;
      if (w_ram_we) begin
        r_ram_d <= i_ram_d;
      end else begin
        r_ram_d <= r_ram_d;
      end
    end
  end

  assign o_start_rdy      = r_start_rdy;
  assign o_val            = r_val;
  assign o_err            = r_err;
  assign o_dat            = r_dat;
  assign o_iter_cnt       = r_iter_cnt;
  assign o_sq_val         = r_sq_val;
  assign o_sq_reduce_only = r_sq_reduce_only;
  assign o_sq_dat         = r_operand;
  assign o_ram_we         = r_ram_we;
  assign o_ram_d          = r_ram_d;

endmodule

// File: doc/vdf_sq_ctrl.md
Name: vdf_sq_ctrl

Overview:
- Sequencer for the polynomial modular squaring datapath (`poly_mod_sq_wrapper`).
- Accepts a starting value `x` and an iteration count `T` from the host, then runs `T` back-to-back squarings by feeding each datapath output back as the next input.
- Finishes with one reduce-only pass and returns the redundant-form result to the host.
- Also gates host writes into the datapath reduction LUT RAM, so the tables cannot change while a computation is in flight.

Parameters:
- `WORD_BITS`, 16, bits per polynomial word.
- `NUM_WORDS`, 64, words per operand.
- `REDUN_WORD_BITS`, 1, redundant bits per coefficient.
- `I_WORD`, `NUM_WORDS+1`, coefficients per datapath operand.
- `COEF_BITS`, `WORD_BITS+REDUN_WORD_BITS`, coefficient width.
- `ITER_BITS`, 40, width of the iteration count.
- `TIMEOUT_CYC`, 256, maximum cycles to wait for a datapath result.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_start`, in, 1: host start request.
- `o_start_rdy`, out, 1: controller can accept a start (IDLE).
- `i_x`, in, `NUM_WORDS*WORD_BITS`: starting integer.
- `i_iter`, in, `ITER_BITS`: number of squarings `T`.
- `i_abort`, in, 1: abandon the current run.
- `o_val`, out, 1: result valid.
- `i_rdy`, in, 1: host accepts the result.
- `o_dat`, out, `I_WORD*COEF_BITS`: result polynomial in redundant form.
- `o_err`, out, 1: qualifies `o_val`; set on timeout.
- `o_iter_cnt`, out, `ITER_BITS`: squarings completed in the current run.
- `o_sq_val`, out, 1: datapath start strobe.
- `o_sq_reduce_only`, out, 1: reduce-only pass select.
- `o_sq_dat`, out, `I_WORD*COEF_BITS`: datapath input.
- `i_sq_val`, in, 1: datapath result valid.
- `i_sq_dat`, in, `I_WORD*COEF_BITS`: datapath result.
- `i_ram_we`, in, 1: host LUT write request.
- `i_ram_d`, in, `NUM_WORDS*WORD_BITS`: host LUT data.
- `o_ram_we`, out, 1: LUT write strobe forwarded to the datapath.
- `o_ram_d`, out, `NUM_WORDS*WORD_BITS`: LUT data forwarded to the datapath.

Behaviour:
- **Reset (async, `i_rst_n`=0):**
  - State IDLE.
  - All outputs 0, except `o_start_rdy`=1.
  - Counters and the operand register are cleared.
- **States:** IDLE, ISSUE, WAIT, FIN_ISSUE, FIN_WAIT, DONE.
- **IDLE:**
  - `i_start` is accepted when `o_start_rdy`=1.
  - On acceptance, register `T` and convert `i_x` to the operand register: coefficient `k` = word `k`, redundant bits 0, top coefficient 0.
  - Clear `o_iter_cnt`.
  - Next state: ISSUE if `T`≠0, else FIN_ISSUE.
- **ISSUE:**
  - `o_sq_val`=1 for exactly one cycle, with `o_sq_reduce_only`=0 and `o_sq_dat`=operand register.
  - Next state: WAIT.
- **WAIT:**
  - On `i_sq_val`, capture `i_sq_dat` into the operand register and increment `o_iter_cnt`.
  - If `o_iter_cnt`+1 == `T`, go to FIN_ISSUE; else go to ISSUE.
  - Per-iteration overhead is one cycle above the datapath latency.
- **FIN_ISSUE:** as ISSUE, but with `o_sq_reduce_only`=1. Next state: FIN_WAIT.
- **FIN_WAIT:** on `i_sq_val`, load `o_dat`, set `o_val`=1 and `o_err`=0, then go to DONE.
- **DONE:**
  - `o_val`, `o_dat` and `o_err` are held stable until `i_rdy`=1.
  - The cycle after the handshake: `o_val`=0, state IDLE.
- **Timeout:**
  - A wait counter is cleared on every issue.
  - In WAIT or FIN_WAIT, if it reaches `TIMEOUT_CYC` without `i_sq_val`: `o_val`=1, `o_err`=1, `o_dat`=operand register, go to DONE.
- **Abort:**
  - `i_abort` in any non-IDLE state returns to IDLE the next cycle with `o_val`=0.
  - No result is produced.
  - Any `i_sq_val` arriving later while IDLE is ignored.
- **Stray results:** `i_sq_val` outside WAIT/FIN_WAIT is ignored.
- **Simultaneous events:**
  - `i_abort` has priority over `i_sq_val` and over timeout.
  - `i_start` asserted together with the DONE handshake is not accepted until IDLE (`o_start_rdy` is registered).
- **LUT gating:**
  - `o_ram_we` = `i_ram_we` AND state==IDLE, registered one cycle, with `o_ram_d` registered alongside it.
  - Writes requested outside IDLE are dropped silently.
- **Iteration counter:** `o_iter_cnt` saturates at `2^ITER_BITS-1`, which is unreachable because `T` is bounded by the same width.
- **Reset mid-run:** immediate return to IDLE; the datapath is not notified.

Decomposition:
- Package `vdf_sq_pkg`:
  - state enum `sq_ctrl_state_t`;
  - typedef `poly_t` (`[I_WORD-1:0][COEF_BITS-1:0]`);
  - function `int_to_poly`;
  - localparam `I_WORD`/`COEF_BITS` derivation.
- One natural sub-module: `vdf_sq_watchdog`, the timeout counter with clear/enable/expired ports.

Test Plan (bench uses a behavioural datapath model with programmable latency 20 and `MODULUS` N):
- **Basic run:** `x`=2, `T`=3 → exactly 4 `o_sq_val` pulses, the last with reduce_only=1; `o_dat` as integer mod N = 256; `o_iter_cnt`=3; `o_err`=0.
- **Zero iterations:** `x`=5, `T`=0 → exactly 1 reduce-only issue; result mod N = 5.
- **Backpressure:** `x`=3, `T`=2, `i_rdy` held low 10 cycles → `o_val` high and `o_dat` stable for all 10 cycles; result mod N = 81; `o_start_rdy`=1 one cycle after the handshake.
- **Timeout:** model never returns, `TIMEOUT_CYC`=64, `T`=5 → `o_val`=`o_err`=1 exactly 64 cycles after the first issue; `o_iter_cnt`=0.
- **Abort:** `i_abort` in WAIT at iteration 2 of `T`=10 → IDLE next cycle, no `o_val`; the late `i_sq_val` is ignored; a following run with `x`=2, `T`=1 gives 4.
- **LUT gating:** `i_ram_we` pulsed in IDLE → one `o_ram_we` pulse one cycle later with matching data; pulsed during WAIT → no `o_ram_we`.
